clk_div_cfg_ctrl: RTL and testbench

Runtime-configurable, glitch-free clock-divider controller that generalises the fixed divide-by-7 block.
- Accepts divisor updates over a valid/ready handshake.
- Applies each update only at an output-period boundary.
- Sequences start and stop so out_clk never produces a runt pulse.
- Generates a 50%-duty out_clk for odd and even divisors; sits between the config/CSR logic and downstream clock consumers.

---
 rtl/clk_div_cfg_ctrl.sv | 125 ++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// Runtime-configurable 50%-duty clock divider with handshake-loaded divisor.
// Divisor changes, starts and stops all take effect on output-period boundaries, so out_clk never emits a runt pulse.
module clk_div_cfg_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             running,
    output logic             period_tick,
    output logic             out_clk
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_q;
    logic             pos_q, neg_q;
    logic             cfg_ready_q, cfg_err_q, running_q, tick_q;
    logic             xfer, div_ok, boundary;

    // ceil(d/2) computed one bit wider so the maximum divisor does not wrap
    function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + (CNT_W + 1)'(1);
        return s[CNT_W:1];
    endfunction

    assign xfer     = cfg_valid & cfg_ready_q;
    assign div_ok   = (cfg_div >= TWO);
    assign boundary = (state_q != IDLE) && (cnt_q == cur_div_q - ONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer && div_ok) cur_div_d = cfg_div;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (!enable) begin
                        // a divisor accepted on the stop boundary is applied right away
                        state_d = IDLE;
                        if (xfer && div_ok) cur_div_d = cfg_div;
                    end else if (xfer && div_ok) begin
                        state_d = PEND;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (xfer && div_ok) state_d = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    cnt_d     = '0;
                    cur_div_d = pend_q;
                    state_d   = enable ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_div_q   <= DIV_RST;
            pend_q      <= '0;
            pos_q       <= 1'b0;
            tick_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            if (state_q == RUN && xfer && div_ok) pend_q <= cfg_div;
            pos_q       <= (state_d != IDLE) && (cnt_d < half_up(cur_div_d));
            tick_q      <= (state_d != IDLE) && (cnt_d == cur_div_d - ONE);
            cfg_ready_q <= (state_d != PEND);
            cfg_err_q   <= xfer & ~div_ok;
            running_q   <= (state_d != IDLE);
        end
    end

    // Half-cycle delayed copy of pos_q trims the odd-divisor high phase to div/2.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= pos_q;
    end

    assign out_clk     = cur_div_q[0] ? (pos_q & neg_q) : pos_q;
    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign cur_div     = cur_div_q;
    assign running     = running_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Randomised bench for clk_div_cfg_ctrl against a phase/half-cycle reference model.
module tb_clk_div_cfg_ctrl;

    localparam int CNT_W = 8;
    localparam int DEF   = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready, cfg_err, running, period_tick, out_clk;
    logic [CNT_W-1:0] cur_div;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_cfg_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .cur_div(cur_div), .running(running), .period_tick(period_tick),
        .out_clk(out_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: is the output running, which divisor, how many cycles into the period.
    bit m_run, m_pv, m_ready, m_err, m_tick, m_xfer, m_ok, m_bnd;
    int m_div, m_pend, m_phase, m_d;

    // Within a period of 2*div half-cycles the high window is div half-cycles long;
    // even divisors start high at the posedge, odd ones half a cycle later.
    function automatic bit exp_out(bit run, int div, int phase, bit second);
        int h;
        h = 2 * phase + (second ? 1 : 0);
        if (!run) return 1'b0;
        if (div % 2 == 0) return (h < div);
        return (h >= 1) && (h <= div);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pv = 0; m_ready = 0; m_err = 0; m_tick = 0;
            m_div = DEF; m_pend = 0; m_phase = 0;
        end else begin
            m_xfer = cfg_valid && m_ready;
            m_d    = int'(cfg_div);
            m_ok   = (m_d >= 2);
            m_bnd  = m_run && (m_phase == m_div - 1);
            if (!m_run) begin
                if (m_xfer && m_ok) m_div = m_d;
                if (enable) begin m_run = 1; m_phase = 0; end
            end else if (m_bnd) begin
                if (m_pv) begin m_div = m_pend; m_pv = 0; end
                if (m_xfer && m_ok) begin
                    if (enable) begin m_pend = m_d; m_pv = 1; end
                    else m_div = m_d;
                end
                m_run   = enable;
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_xfer && m_ok) begin m_pend = m_d; m_pv = 1; end
            end
            m_err   = m_xfer && !m_ok;
            m_ready = !m_pv;
            m_tick  = m_run && (m_phase == m_div - 1);
        end
    end

    always @(posedge clk) begin
        #1;
        check("out_clk_pos", int'(out_clk), int'(exp_out(m_run, m_div, m_phase, 1'b0)));
        check("cur_div", int'(cur_div), m_div);
        check("running", int'(running), int'(m_run));
        check("period_tick", int'(period_tick), int'(m_tick));
        check("cfg_ready", int'(cfg_ready), int'(m_ready));
        check("cfg_err", int'(cfg_err), int'(m_err));
    end

    always @(negedge clk) begin
        #1;
        check("out_clk_neg", int'(out_clk), int'(exp_out(m_run, m_div, m_phase, 1'b1)));
    end

    // Offer a divisor and hold it until the controller takes it.
    task automatic send(input logic [CNT_W-1:0] d);
        bit rdy;
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_div   = d;
        do begin
            rdy = cfg_ready;
            @(posedge clk); #2;
            n++;
        end while (!rdy && n < 600);
        cfg_valid = 1'b0;
        if (!rdy) check("send_timeout", 0, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        bit found, rdy;
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        enable = 1'b1;
        #29 rst_n = 1'b1;
        @(posedge clk); #2;

        // default divide-by-7, then even reconfig, invalid write
        wait_cycles(30);
        send(8'd4);
        wait_cycles(25);
        send(8'd1);
        wait_cycles(10);
        send(8'd7);
        wait_cycles(20);

        // stop mid-period, then restart
        enable = 1'b0;
        wait_cycles(20);
        enable = 1'b1;
        wait_cycles(20);

        // async reset while out_clk is high
        found = 0;
        n = 0;
        while (!found && n < 50) begin
            @(posedge clk); #2;
            found = out_clk;
            n++;
        end
        check("find_high_phase", int'(found), 1);
        #1 rst_n = 1'b0;
        #1 check("async_rst_out_clk", int'(out_clk), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("rst_cur_div", int'(cur_div), DEF);
        wait_cycles(15);

        // transfer landing exactly on a period boundary
        found = 0;
        n = 0;
        while (!found && n < 50) begin
            @(posedge clk); #2;
            found = period_tick;
            n++;
        end
        check("find_tick", int'(found), 1);
        send(8'd3);
        wait_cycles(30);

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            rdy = cfg_ready;
            enable = ($urandom_range(0, 15) != 0);
            if (!cfg_valid && $urandom_range(0, 7) == 0) begin
                cfg_valid = 1'b1;
                cfg_div   = CNT_W'($urandom_range(0, 12));
            end
            @(posedge clk); #2;
            if (cfg_valid && rdy) cfg_valid = 1'b0;
        end
        cfg_valid = 1'b0;
        enable    = 1'b1;
        wait_cycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
